// File: rtl/id_instr_queue_pkg.sv
// Shared types for the IF/ID instruction queue.
package id_pkg;

  typedef enum logic {
    RUN,
    DS_WAIT
  } queue_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/id_instr_queue_if.sv
// Fetch/decode-facing handshake bundle of the instruction queue.
interface id_instr_queue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               push_valid;
  logic               push_ready;
  logic [INSTR_W-1:0] push_instr;
  logic [PC_W-1:0]    push_pc;
  logic               pop_valid;
  logic               pop_ready;
  logic [INSTR_W-1:0] pop_instr;
  logic [PC_W-1:0]    pop_pc;
  logic [PC_W-1:0]    pop_pc_plus_4;
  logic               redirect;
  logic               flush;
  logic               ds_pending;
  logic [CW-1:0]      count;

  modport master (
    output push_valid, push_instr, push_pc, pop_ready, redirect, flush,
    input  push_ready, pop_valid, pop_instr, pop_pc, pop_pc_plus_4, ds_pending, count
  );

  modport slave (
    input  push_valid, push_instr, push_pc, pop_ready, redirect, flush,
    output push_ready, pop_valid, pop_instr, pop_pc, pop_pc_plus_4, ds_pending, count
  );
endinterface

// File: rtl/id_instr_queue_ram.sv
// DEPTH x W register array, one write port, one async read port, reset to zero.
module id_queue_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Write port: update the addressed entry only.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage register with async clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_instr_queue.sv
// IF/ID instruction FIFO with delay-slot-aware redirect and full flush.
module id_instr_queue
  import id_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_instr_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = INSTR_W + PC_W;

  queue_state_t  state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, do_redir, wr_en;
  logic [W-1:0]  rd_data;

  assign q.push_ready = (count_q != CW'(DEPTH));
  assign q.pop_valid  = (count_q != '0);
  assign do_push      = q.push_valid & q.push_ready;
  assign do_pop       = q.pop_valid & q.pop_ready;
  assign do_redir     = do_pop & q.redirect;

  // Next pointers/count/state; flush beats redirect beats plain FIFO traffic.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (q.flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      state_d  = RUN;
    end else if (do_redir) begin
      if (count_q > CW'(1)) begin
        // Entry behind the popped one is the delay slot; drop everything after it.
        rd_ptr_d = rd_ptr_q + AW'(1);
        wr_ptr_d = rd_ptr_q + AW'(2);
        count_d  = CW'(1);
      end else if (do_push) begin
        // Queue drains to empty, so the incoming push is the delay slot.
        wr_en    = 1'b1;
        rd_ptr_d = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = CW'(1);
      end else begin
        // Delay slot not fetched yet; IF must deliver it before the target.
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = '0;
        state_d  = DS_WAIT;
      end
    end else begin
      if (do_push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (state_q == DS_WAIT && do_push) state_d = RUN;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  id_queue_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata ({q.push_instr, q.push_pc}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign q.pop_instr     = rd_data[W-1:PC_W];
  assign q.pop_pc        = rd_data[PC_W-1:0];
  assign q.pop_pc_plus_4 = rd_data[PC_W-1:0] + PC_W'(4);
  assign q.ds_pending    = (state_q == DS_WAIT);
  assign q.count         = count_q;

endmodule

// File: tb/tb_id_instr_queue.sv
// Directed bench for id_instr_queue.
module tb_id_instr_queue;
  import id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  id_instr_queue_if #(.DEPTH(4), .INSTR_W(32), .PC_W(32)) qi ();

  id_instr_queue #(.DEPTH(4), .INSTR_W(32), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qi)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    qi.push_valid = 1'b0;
    qi.push_pc    = '0;
    qi.push_instr = '0;
    qi.pop_ready  = 1'b0;
    qi.redirect   = 1'b0;
    qi.flush      = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc);
    entry_t e;
    e.pc  = pc;
    e.instr = pc ^ 32'hA5A5_0000;
    qi.push_valid = 1'b1;
    qi.push_pc    = e.pc;
    qi.push_instr = e.instr;
  endtask

  task automatic push1(input logic [31:0] pc);
    idle;
    offer(pc);
    tick;
    idle;
  endtask

  task automatic pop1;
    idle;
    qi.pop_ready = 1'b1;
    tick;
    idle;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    idle;
    rst = 1'b0;
    #2;
    chk("rst_pop_valid", qi.pop_valid, 0);
    chk("rst_push_ready", qi.push_ready, 1);
    chk("rst_pop_instr", qi.pop_instr, INSTR_NOP);
    chk("rst_pop_pc", qi.pop_pc, 0);
    chk("rst_plus4", qi.pop_pc_plus_4, 32'h4);
    chk("rst_ds", qi.ds_pending, 0);
    chk("rst_count", qi.count, 0);
    #10 rst = 1'b1;
    tick;

    // Fill to full, then drain; the push offered while full must be dropped.
    for (int k = 0; k < 4; k++) begin
      push1(32'h100 + 4 * k);
      chk("fill_count", qi.count, k + 1);
    end
    chk("fill_push_ready", qi.push_ready, 0);
    offer(32'hBAD0);
    qi.pop_ready = 1'b1;
    chk("drain_pc0", qi.pop_pc, 32'h100);
    chk("drain_p4_0", qi.pop_pc_plus_4, 32'h104);
    tick;
    idle;
    chk("full_no_push", qi.count, 3);
    for (int k = 1; k < 4; k++) begin
      chk("drain_pc", qi.pop_pc, 32'h100 + 4 * k);
      chk("drain_p4", qi.pop_pc_plus_4, 32'h104 + 4 * k);
      chk("drain_instr", qi.pop_instr, (32'h100 + 4 * k) ^ 32'hA5A5_0000);
      pop1;
    end
    chk("drain_empty", qi.pop_valid, 0);

    // Redirect from a full queue: keep the delay slot only.
    for (int k = 0; k < 4; k++) push1(32'h200 + 4 * k);
    offer(32'h210);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    tick;
    idle;
    chk("redir_full_count", qi.count, 1);
    chk("redir_full_head", qi.pop_pc, 32'h204);
    chk("redir_full_ds", qi.ds_pending, 0);
    pop1;
    chk("redir_full_gone", qi.pop_valid, 0);

    // Redirect with R=2 and an accepted push: push and tail discarded.
    for (int k = 0; k < 3; k++) push1(32'h220 + 4 * k);
    offer(32'h22C);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    tick;
    idle;
    chk("redir3_count", qi.count, 1);
    chk("redir3_head", qi.pop_pc, 32'h224);
    pop1;
    chk("redir3_gone", qi.pop_valid, 0);

    // Redirect on last entry with no push: wait for delay slot.
    push1(32'h300);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    tick;
    idle;
    chk("dsw_pending", qi.ds_pending, 1);
    chk("dsw_count", qi.count, 0);
    push1(32'h304);
    chk("dsw_clear", qi.ds_pending, 0);
    chk("dsw_head", qi.pop_pc, 32'h304);
    chk("dsw_count1", qi.count, 1);
    pop1;

    // Redirect on last entry with same-cycle push: that push is the slot.
    push1(32'h600);
    offer(32'h604);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    tick;
    idle;
    chk("r0p_count", qi.count, 1);
    chk("r0p_head", qi.pop_pc, 32'h604);
    chk("r0p_ds", qi.ds_pending, 0);
    pop1;

    // Flush beats push, pop and redirect.
    for (int k = 0; k < 3; k++) push1(32'h410 + 4 * k);
    offer(32'h400);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    qi.flush     = 1'b1;
    tick;
    idle;
    chk("flush_count", qi.count, 0);
    chk("flush_ds", qi.ds_pending, 0);
    chk("flush_valid", qi.pop_valid, 0);
    push1(32'h420);
    chk("flush_realign", qi.pop_pc, 32'h420);
    pop1;

    // Flush out of DS_WAIT.
    push1(32'h430);
    qi.pop_ready = 1'b1;
    qi.redirect  = 1'b1;
    tick;
    idle;
    chk("dsflush_pre", qi.ds_pending, 1);
    qi.flush = 1'b1;
    tick;
    idle;
    chk("dsflush_post", qi.ds_pending, 0);

    // Wrap-around with interleaved traffic against a reference queue.
    for (int k = 0; k < 10; k++) begin
      int sz;
      idle;
      offer(32'h500 + 4 * k);
      qi.pop_ready = (k % 3 == 2);
      sz = mq.size();
      chk("wrap_count", qi.count, sz);
      chk("wrap_valid", qi.pop_valid, sz != 0);
      if (sz != 0 && qi.pop_ready) begin
        chk("wrap_pc", qi.pop_pc, mq[0]);
        void'(mq.pop_front());
      end
      if (sz < 4) mq.push_back(32'h500 + 4 * k);
      tick;
    end
    idle;
    for (int i = 0; i < 8 && mq.size() != 0; i++) begin
      chk("wrap_drain", qi.pop_pc, mq[0]);
      void'(mq.pop_front());
      pop1;
    end
    chk("wrap_empty", qi.pop_valid, 0);

    // Asynchronous reset mid-cycle.
    push1(32'h700);
    push1(32'h704);
    chk("arst_pre", qi.count, 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_count", qi.count, 0);
    chk("arst_valid", qi.pop_valid, 0);
    chk("arst_ready", qi.push_ready, 1);
    chk("arst_pc", qi.pop_pc, 0);
    chk("arst_instr", qi.pop_instr, 0);
    chk("arst_p4", qi.pop_pc_plus_4, 32'h4);
    chk("arst_ds", qi.ds_pending, 0);
    @(negedge clk);
    rst = 1'b1;
    push1(32'h800);
    chk("arst_after", qi.pop_pc, 32'h800);
    chk("arst_after_cnt", qi.count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_instr_queue.md
# id_instr_queue

Parametrised instruction queue between the IF/ID register and the decode stage, replacing the single-entry IF/ID latch with a DEPTH-entry FIFO of {instruction, PC}. Decouples fetch from decode stalls and implements MIPS branch-delay-slot-aware redirect. A taken branch or jump retires the wrong-path entries but keeps the delay slot. Exceptions and ERET flush everything.

## Interface
- DEPTH, 4, entry count; power of two, ≥2
- INSTR_W, 32, instruction width
- PC_W, 32, PC width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- push_valid  in  1  IF offers an entry
- push_ready  out  1  queue can accept; = (count != DEPTH)
- push_instr  in  INSTR_W  fetched instruction
- push_pc  in  PC_W  its PC
- pop_valid  out  1  head entry valid; = (count != 0)
- pop_ready  in  1  decode consumes head
- pop_instr  out  INSTR_W  head instruction
- pop_pc  out  PC_W  head PC
- pop_pc_plus_4  out  PC_W  pop_pc + 4, modulo 2^PC_W
- redirect  in  1  decode resolved a taken branch/jump on the entry being popped this cycle
- flush  in  1  exception/ERET: discard all contents
- ds_pending  out  1  delay slot not yet fetched; IF must push it before applying the target PC
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer; rd_ptr, wr_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count tracks occupancy, 0..DEPTH.
- Push accepted when push_valid & push_ready. Pop accepted when pop_valid & pop_ready. Both may happen in one cycle; count unchanged.
- State machine, two states:
  - RUN: normal FIFO.
  - DS_WAIT: ds_pending=1. Next accepted push is kept as the delay slot, then → RUN.
- Redirect is accepted only when redirect & pop handshake; redirect without a pop is ignored (bench asserts it never happens). On accepted redirect in RUN, let R = entries remaining after the pop:
  - R ≥ 1: keep the oldest remaining entry (delay slot), discard the rest and any same-cycle push; count ← 1; stay RUN.
  - R = 0 with a same-cycle push: keep that push as the delay slot; count ← 1; stay RUN.
  - R = 0 with no push: count ← 0; → DS_WAIT.
- A redirect in DS_WAIT cannot occur (queue empty, so no pop).
- flush: count ← 0, rd_ptr ← wr_ptr, state → RUN. Same-cycle push, pop and redirect are discarded. flush has priority over everything.
- Reset: count 0, pointers 0, state RUN, storage 0. Outputs: pop_valid 0, push_ready 1, pop_instr 0, pop_pc 0, pop_pc_plus_4 4, ds_pending 0, count 0.

## Timing
- Push→pop latency 1 cycle; no same-cycle bypass when empty.
- push_ready depends only on registered count, not on pop_ready. When full, a same-cycle pop does not enable a push.
- Pop outputs are combinational from head storage and valid in the cycle pop_valid is high. They stay stable until popped.
- ds_pending is registered; it rises the cycle after the redirect and falls the cycle after the delay-slot push.
- Reset deassertion mid-operation: the first edge after release behaves as RUN with an empty queue.

## Structure
- Shared package id_pkg holds:
  - the queue_state_t enum {RUN, DS_WAIT}
  - the entry struct {instr, pc}
  - the INSTR_NOP constant 32'h0000_0000
- One sub-module, id_queue_ram: DEPTH×(INSTR_W+PC_W) register array with one write port and one async read port, reset to zero.
- Pointer, count and FSM logic stay in id_instr_queue.

## Test plan
- Fill/drain: push PCs 0x100, 0x104, 0x108, 0x10C with pop_ready=0. Expect push_ready=0 at count 4. Pop all four in order with pop_pc_plus_4 = 0x104…0x110; then pop_valid=0.
- Redirect with entries: queue holds 0x200..0x20C; pop 0x200 with redirect plus a same-cycle push 0x210. Expect count=1 and the head 0x204; 0x208, 0x20C and 0x210 are gone.
- Redirect on empty: queue holds only 0x300; pop with redirect, no push. Expect ds_pending=1 next cycle. Push 0x304: head 0x304 and ds_pending=0 the following cycle.
- Flush priority: queue holds 3 entries; assert flush with push 0x400, pop and redirect in the same cycle. Expect count=0, ds_pending=0, pop_valid=0.
- Wrap-around: 10 interleaved push/pop cycles at DEPTH=4 with PCs 0x500+4k. Expect pops in order, no loss, count never >4.
- Async reset: assert rst low mid-cycle while count=2. Expect outputs at reset values immediately, without waiting for a clock edge.
